// File: rtl/pdp8_tt_fifo_if.sv
// rtl/pdp8_tt_fifo_if.sv - PDP-8 IO bus plus UART byte-stream bundle for one console line
interface pdp8_tt_fifo_if #(
    parameter int CHAR_W     = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  iot;
    logic [3:0]            state;
    logic [11:0]           mb;
    logic [5:0]            io_select;
    logic [11:0]           io_data_in;
    logic [11:0]           io_data_out;
    logic                  io_selected;
    logic                  io_data_avail;
    logic                  io_interrupt;
    logic                  io_skip;
    logic [CHAR_W-1:0]     rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [CHAR_W-1:0]     tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  rx_ovf;
    logic                  tx_ovf;
    logic [DEPTH_LOG2:0]   rx_count;
    logic [DEPTH_LOG2:0]   tx_count;

    // master: CPU bus plus UART side; slave: the line front-end
    modport master (
        output iot, state, mb, io_select, io_data_in, rx_data, rx_valid, tx_ready,
        input  io_data_out, io_selected, io_data_avail, io_interrupt, io_skip,
               rx_ready, tx_data, tx_valid, rx_ovf, tx_ovf, rx_count, tx_count
    );

    modport slave (
        input  iot, state, mb, io_select, io_data_in, rx_data, rx_valid, tx_ready,
        output io_data_out, io_selected, io_data_avail, io_interrupt, io_skip,
               rx_ready, tx_data, tx_valid, rx_ovf, tx_ovf, rx_count, tx_count
    );
endinterface

// File: rtl/pdp8_tt_fifo.sv
// rtl/pdp8_tt_fifo.sv - KL8-style keyboard/printer IOT front-end with RX and TX character FIFOs

module pdp8_tt_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    // Acceptance depends only on occupancy at cycle start, so a full FIFO
    // refuses a push even when it is being popped in the same cycle.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end
endmodule

module pdp8_tt_fifo #(
    parameter logic [5:0] DEV_RX     = 6'o03,
    parameter logic [5:0] DEV_TX     = 6'o04,
    parameter int         CHAR_W     = 8,
    parameter int         DEPTH_LOG2 = 4,
    parameter int         RX_DROP    = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    pdp8_tt_fifo_if.slave   bus
);
    localparam logic [3:0] ST_F1 = 4'b0001;
    localparam logic       DROP  = (RX_DROP != 0);

    typedef enum logic {S_IDLE, S_PEND} pend_state_t;

    pend_state_t            r_state;
    pend_state_t            w_state_nx;

    logic                   w_sel_rx;
    logic                   w_sel_tx;
    logic                   w_win;
    logic                   w_first;
    logic                   w_commit;
    logic                   r_win_d;

    logic                   r_pend_rx;
    logic [2:0]             r_pend_op;
    logic [11:0]            r_pend_data;

    logic                   r_rx_flag;
    logic                   r_tx_flag;
    logic                   r_ie;
    logic                   r_rx_ovf;
    logic                   r_tx_ovf;

    logic                   w_c_rx;
    logic                   w_c_tx;
    logic                   w_op_26;
    logic                   w_rx_clr;
    logic                   w_rx_pop;
    logic                   w_ie_wr;
    logic                   w_tx_set;
    logic                   w_tx_clr;
    logic                   w_tx_push;
    logic                   w_rx_push;

    logic [CHAR_W-1:0]      w_rx_head;
    logic [DEPTH_LOG2:0]    w_rx_count;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic [CHAR_W-1:0]      w_tx_head;
    logic [DEPTH_LOG2:0]    w_tx_count;
    logic                   w_tx_full;
    logic                   w_tx_empty;

    logic                   w_intr;
    logic [2:0]             w_op;
    logic [11:0]            w_rx_head12;
    logic [11:0]            w_data_out;
    logic                   w_skip;
    logic                   w_unused;

    assign w_unused = ^bus.mb[11:3];

    // Window is gated by reset so nothing appears selected while held in reset.
    assign w_sel_rx = (bus.io_select == DEV_RX);
    assign w_sel_tx = (bus.io_select == DEV_TX);
    assign w_win    = reset_n & bus.iot & (bus.state == ST_F1) & (w_sel_rx | w_sel_tx);
    assign w_first  = w_win & ~r_win_d;
    assign w_op     = bus.mb[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: if (w_first) w_state_nx = S_PEND;
            S_PEND: begin
                if (!w_win) begin
                    w_state_nx = S_IDLE;
                    w_commit   = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // r_win_d resets high so a window still asserted as reset releases is
    // not mistaken for a fresh IOT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_d     <= 1'b1;
            r_pend_rx   <= 1'b0;
            r_pend_op   <= 3'd0;
            r_pend_data <= 12'd0;
        end else begin
            r_win_d <= w_win;
            if (w_first) begin
                r_pend_rx   <= w_sel_rx;
                r_pend_op   <= w_op;
                r_pend_data <= bus.io_data_in;
            end
        end
    end

    assign w_c_rx    = w_commit & r_pend_rx;
    assign w_c_tx    = w_commit & ~r_pend_rx;
    assign w_op_26   = (r_pend_op == 3'd2) | (r_pend_op == 3'd6);
    assign w_rx_clr  = w_c_rx & ((r_pend_op == 3'd0) | w_op_26);
    assign w_rx_pop  = w_c_rx & w_op_26;
    assign w_ie_wr   = w_c_rx & (r_pend_op == 3'd5);
    assign w_tx_set  = w_c_tx & (r_pend_op == 3'd0);
    assign w_tx_clr  = w_c_tx & w_op_26;
    assign w_tx_push = w_c_tx & ((r_pend_op == 3'd4) | (r_pend_op == 3'd6));
    assign w_rx_push = bus.rx_valid & (DROP | ~w_rx_full);

    pdp8_tt_fifo_buf #(.W(CHAR_W), .AW(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_wdata (bus.rx_data),
        .o_rdata (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    pdp8_tt_fifo_buf #(.W(CHAR_W), .AW(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_tx_push),
        .i_pop   (bus.tx_ready),
        .i_wdata (r_pend_data[CHAR_W-1:0]),
        .o_rdata (w_tx_head),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    // Commit cycles apply only the IOT's own flag effects; re-arm waits for
    // the next idle cycle so a clear is visible for at least one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_flag <= 1'b0;
            r_tx_flag <= 1'b0;
            r_ie      <= 1'b1;
            r_rx_ovf  <= 1'b0;
            r_tx_ovf  <= 1'b0;
        end else begin
            if (w_commit) begin
                if (w_rx_clr) r_rx_flag <= 1'b0;
                if (w_tx_clr) r_tx_flag <= 1'b0;
                if (w_tx_set) r_tx_flag <= 1'b1;
                if (w_ie_wr)  r_ie      <= r_pend_data[0];
            end else if (!w_win) begin
                if (!w_rx_empty) r_rx_flag <= 1'b1;
                if (!w_tx_full)  r_tx_flag <= 1'b1;
            end
            if (w_tx_push & w_tx_full) r_tx_ovf <= 1'b1;
            if (DROP & bus.rx_valid & w_rx_full) r_rx_ovf <= 1'b1;
        end
    end

    assign w_intr      = r_ie & (r_rx_flag | r_tx_flag);
    assign w_rx_head12 = w_rx_empty ? 12'd0 : 12'(w_rx_head);

    always_comb begin
        w_data_out = bus.io_data_in;
        w_skip     = 1'b0;
        if (w_win && w_sel_rx) begin
            case (w_op)
                3'd1:    w_skip     = r_rx_flag;
                3'd4,
                3'd6:    w_data_out = w_rx_head12;
                default: if (w_op[1]) w_data_out = 12'd0;
            endcase
        end else if (w_win && w_sel_tx) begin
            case (w_op)
                3'd1:    w_skip = r_tx_flag;
                3'd5:    w_skip = w_intr;
                default: w_skip = 1'b0;
            endcase
        end
    end

    assign bus.io_data_out   = w_data_out;
    assign bus.io_skip       = w_skip;
    assign bus.io_selected   = w_win;
    assign bus.io_data_avail = 1'b1;
    assign bus.io_interrupt  = w_intr;
    assign bus.rx_ready      = DROP | ~w_rx_full;
    assign bus.tx_data       = w_tx_head;
    assign bus.tx_valid      = ~w_tx_empty;
    assign bus.rx_ovf        = r_rx_ovf;
    assign bus.tx_ovf        = r_tx_ovf;
    assign bus.rx_count      = w_rx_count;
    assign bus.tx_count      = w_tx_count;
endmodule

// File: tb/tb_pdp8_tt_fifo.sv
// tb/tb_pdp8_tt_fifo.sv - queue-model checked bench for pdp8_tt_fifo plus an RX_DROP=1 instance
module tb_pdp8_tt_fifo;
    localparam int CW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam logic [5:0] DRX = 6'o03;
    localparam logic [5:0] DTX = 6'o04;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pdp8_tt_fifo_if #(.CHAR_W(CW), .DEPTH_LOG2(AW)) bus ();
    pdp8_tt_fifo_if #(.CHAR_W(CW), .DEPTH_LOG2(AW)) bus2 ();

    pdp8_tt_fifo #(.DEV_RX(DRX), .DEV_TX(DTX), .CHAR_W(CW), .DEPTH_LOG2(AW), .RX_DROP(0))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    pdp8_tt_fifo #(.DEV_RX(DRX), .DEV_TX(DTX), .CHAR_W(CW), .DEPTH_LOG2(AW), .RX_DROP(1))
        dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    int checks = 0;
    int failures = 0;
    bit rnd_uart = 1'b0;
    logic [7:0] popped [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queues for the FIFOs, plain bits for flags and the pending IOT.
    logic [7:0]  m_rxq [$];
    logic [7:0]  m_txq [$];
    bit          m_rxf, m_txf, m_ie, m_rxovf, m_txovf;
    bit          m_pv, m_prx, m_pwin;
    logic [2:0]  m_pop;
    logic [11:0] m_pd;

    function automatic bit win_now();
        return reset_n && bus.iot && bus.state == 4'b0001 &&
               (bus.io_select == DRX || bus.io_select == DTX);
    endfunction

    task automatic m_reset();
        m_rxq.delete();
        m_txq.delete();
        m_rxf = 0; m_txf = 0; m_ie = 1; m_rxovf = 0; m_txovf = 0;
        m_pv = 0; m_prx = 0; m_pwin = 1; m_pop = 0; m_pd = 0;
    endtask

    task automatic m_step();
        bit win, commit, rx_push, rx_pop, tx_req, tx_pop;
        int rxn, txn;
        logic [7:0] d;
        win    = win_now();
        commit = m_pv && !win;
        rxn    = m_rxq.size();
        txn    = m_txq.size();
        rx_push = bus.rx_valid && rxn < DEPTH;
        rx_pop  = commit && m_prx && (m_pop == 2 || m_pop == 6) && rxn > 0;
        tx_req  = commit && !m_prx && (m_pop == 4 || m_pop == 6);
        tx_pop  = bus.tx_ready && txn > 0;
        if (rx_pop) d = m_rxq.pop_front();
        if (rx_push) m_rxq.push_back(bus.rx_data);
        if (tx_pop) d = m_txq.pop_front();
        if (tx_req) begin
            if (txn < DEPTH) m_txq.push_back(m_pd[7:0]);
            else m_txovf = 1;
        end
        if (commit) begin
            if (m_prx) begin
                if (m_pop == 0 || m_pop == 2 || m_pop == 6) m_rxf = 0;
                if (m_pop == 5) m_ie = m_pd[0];
            end else begin
                if (m_pop == 0) m_txf = 1;
                if (m_pop == 2 || m_pop == 6) m_txf = 0;
            end
            m_pv = 0;
        end else if (!win) begin
            if (rxn > 0) m_rxf = 1;
            if (txn < DEPTH) m_txf = 1;
        end
        if (win && !m_pwin) begin
            m_pv = 1;
            m_prx = (bus.io_select == DRX);
            m_pop = bus.mb[2:0];
            m_pd  = bus.io_data_in;
        end
        m_pwin = win;
    endtask

    always @(posedge clk) begin
        if (!reset_n) m_reset();
        else m_step();
        if (reset_n && bus.tx_valid === 1'b1 && bus.tx_ready) popped.push_back(bus.tx_data);
    end

    always @(negedge clk) begin
        bit win, skip;
        logic [11:0] dout;
        logic [2:0] op;
        if (!reset_n) m_reset();
        win  = win_now();
        op   = bus.mb[2:0];
        dout = bus.io_data_in;
        skip = 0;
        if (win && bus.io_select == DRX) begin
            if (op == 1) skip = m_rxf;
            else if (op == 4 || op == 6) dout = (m_rxq.size() > 0) ? {4'd0, m_rxq[0]} : 12'd0;
            else if (op[1]) dout = 12'd0;
        end else if (win) begin
            if (op == 1) skip = m_txf;
            if (op == 5) skip = m_ie && (m_rxf || m_txf);
        end
        chk("io_selected", bus.io_selected, win);
        chk("io_skip", bus.io_skip, skip);
        chk("io_data_out", bus.io_data_out, dout);
        chk("io_data_avail", bus.io_data_avail, 1);
        chk("io_interrupt", bus.io_interrupt, m_ie && (m_rxf || m_txf));
        chk("rx_ready", bus.rx_ready, m_rxq.size() < DEPTH);
        chk("tx_valid", bus.tx_valid, m_txq.size() > 0);
        if (m_txq.size() > 0) chk("tx_data", bus.tx_data, m_txq[0]);
        chk("rx_count", bus.rx_count, m_rxq.size());
        chk("tx_count", bus.tx_count, m_txq.size());
        chk("rx_ovf", bus.rx_ovf, m_rxovf);
        chk("tx_ovf", bus.tx_ovf, m_txovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_uart) begin
            bus.rx_valid = 1'($urandom_range(0, 1));
            bus.rx_data  = 8'($urandom);
            bus.tx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic open_win(input logic [5:0] dev, input logic [3:0] st, input logic [2:0] op,
                            input logic [11:0] ac);
        bus.iot = 1'b1;
        bus.state = st;
        bus.io_select = dev;
        bus.mb = {3'o6, dev, op};
        bus.io_data_in = ac;
    endtask

    task automatic close_win();
        bus.iot = 1'b0;
        bus.state = 4'b0010;
        bus.io_data_in = 12'($urandom);
    endtask

    task automatic iot(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac,
                       input int f1, output logic [11:0] dout, output logic skip);
        open_win(dev, 4'b0001, op, ac);
        @(negedge clk);
        dout = bus.io_data_out;
        skip = bus.io_skip;
        repeat (f1) tick();
        close_win();
        repeat (3) tick();
        @(negedge clk);
    endtask

    logic [11:0] d;
    logic s;

    initial begin
        bus.iot = 0; bus.state = 0; bus.mb = 0; bus.io_select = 0; bus.io_data_in = 0;
        bus.rx_data = 0; bus.rx_valid = 0; bus.tx_ready = 0;
        bus2.iot = 0; bus2.state = 0; bus2.mb = 0; bus2.io_select = 0; bus2.io_data_in = 0;
        bus2.rx_data = 0; bus2.rx_valid = 0; bus2.tx_ready = 0;

        repeat (3) tick();
        @(negedge clk);
        chk("reset tx_valid", bus.tx_valid, 0);
        chk("reset io_interrupt", bus.io_interrupt, 0);
        chk("reset tx_count", bus.tx_count, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // reset dropped while a TLS is pending
        open_win(DTX, 4'b0001, 3'd6, 12'h0aa);
        repeat (2) tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid-reset io_selected", bus.io_selected, 0);
        chk("mid-reset io_skip", bus.io_skip, 0);
        tick();
        close_win();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("post-reset tx_count", bus.tx_count, 0);
        chk("post-reset tx_valid", bus.tx_valid, 0);
        chk("post-reset ie interrupt", bus.io_interrupt, 1);

        // RX three chars then KRB with long F1
        bus.tx_ready = 1;
        for (int k = 0; k < 3; k++) begin
            bus.rx_valid = 1; bus.rx_data = 8'(12'o301 + k);
            tick();
        end
        bus.rx_valid = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("rx_count 3", bus.rx_count, 3);
        iot(DRX, 3'd1, 12'o7777, 1, d, s);
        chk("KSF skip", s, 1);
        for (int k = 0; k < 3; k++) begin
            iot(DRX, 3'd6, 12'o7777, 3, d, s);
            chk("KRB data", d, 12'o301 + k);
            chk("KRB rx_count", bus.rx_count, 2 - k);
        end
        iot(DRX, 3'd1, 12'd0, 1, d, s);
        chk("KSF after drain", s, 0);

        // TX fill past full
        bus.tx_ready = 0;
        for (int i = 0; i < 17; i++) iot(DTX, 3'd6, 12'(12'h040 + i), 1, d, s);
        chk("tx full count", bus.tx_count, 16);
        chk("tx_ovf", bus.tx_ovf, 1);
        iot(DTX, 3'd1, 12'd0, 1, d, s);
        chk("TSF full", s, 0);
        popped.delete();
        bus.tx_ready = 1;
        repeat (20) tick();
        chk("tx drained", popped.size(), 16);
        for (int i = 0; i < 16 && i < popped.size(); i++) chk("tx order", popped[i], 8'h40 + i);
        iot(DTX, 3'd1, 12'd0, 1, d, s);
        chk("TSF empty", s, 1);

        // interrupt enable
        bus.rx_valid = 1; bus.rx_data = 8'h55;
        tick();
        bus.rx_valid = 0;
        repeat (2) tick();
        iot(DRX, 3'd5, 12'd0, 1, d, s);
        chk("KIE0 interrupt", bus.io_interrupt, 0);
        chk("KIE AC through", d, 12'd0);
        iot(DRX, 3'd1, 12'd0, 1, d, s);
        chk("rx_flag set", s, 1);
        iot(DRX, 3'd5, 12'd1, 1, d, s);
        chk("KIE1 interrupt", bus.io_interrupt, 1);
        iot(DTX, 3'd5, 12'd0, 2, d, s);
        chk("SPI skip", s, 1);
        iot(DRX, 3'd6, 12'd0, 1, d, s);
        chk("KRB 0x55", d, 12'h055);

        // UART pop coinciding with a TLS commit at count 5
        bus.tx_ready = 0;
        for (int i = 0; i < 5; i++) iot(DTX, 3'd6, 12'(12'h010 + i), 1, d, s);
        chk("tx_count 5", bus.tx_count, 5);
        popped.delete();
        open_win(DTX, 4'b0001, 3'd6, 12'h015);
        tick();
        close_win();
        bus.tx_ready = 1;
        tick();
        bus.tx_ready = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("tx_count same-cycle", bus.tx_count, 5);
        bus.tx_ready = 1;
        repeat (8) tick();
        chk("tx popped total", popped.size(), 6);
        for (int i = 0; i < 6 && i < popped.size(); i++) chk("tx order 2", popped[i], 8'h10 + i);

        // RX backpressure with RX_DROP=0
        bus.rx_valid = 1;
        for (int i = 0; i < 18; i++) begin
            bus.rx_data = 8'($urandom);
            tick();
        end
        @(negedge clk);
        chk("rx full ready", bus.rx_ready, 0);
        chk("rx full count", bus.rx_count, 16);
        bus.rx_valid = 0;

        // randomized IOT and UART traffic against the model
        rnd_uart = 1;
        for (int n = 0; n < 250; n++) begin
            int sel;
            logic [5:0] dev;
            logic [3:0] st;
            sel = $urandom_range(0, 5);
            dev = (sel == 4) ? 6'o05 : ((sel[0]) ? DTX : DRX);
            st  = (sel == 5) ? 4'b0010 : 4'b0001;
            open_win(dev, st, 3'($urandom), 12'($urandom));
            repeat ($urandom_range(1, 3)) tick();
            close_win();
            repeat ($urandom_range(2, 4)) tick();
        end
        rnd_uart = 0;
        bus.rx_valid = 0;
        repeat (3) tick();

        // RX_DROP=1 instance: always ready, overflow is sticky
        bus2.rx_valid = 1;
        for (int i = 0; i < 16; i++) begin
            bus2.rx_data = 8'(i + 1);
            tick();
        end
        @(negedge clk);
        chk("drop count 16", bus2.rx_count, 16);
        chk("drop ovf before", bus2.rx_ovf, 0);
        chk("drop rx_ready", bus2.rx_ready, 1);
        bus2.rx_data = 8'hee;
        tick();
        bus2.rx_valid = 0;
        tick();
        @(negedge clk);
        chk("drop count after", bus2.rx_count, 16);
        chk("drop ovf after", bus2.rx_ovf, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
